// File: rtl/mul_accumulator.sv
// mul_accumulator: sums products from a LATENCY-deep pipelined multiplier into dot-product results.
// Define MUL_ACCUMULATOR_SATURATE_EN to clamp the accumulator on carry instead of wrapping.
module mul_accumulator #(
    parameter int LATENCY = 3,
    parameter int ACC_W   = 24
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             op_valid,
    input  logic             op_last,
    input  logic             clr,
    input  logic [15:0]      prod,
    output logic [ACC_W-1:0] acc_out,
    output logic [7:0]       n_terms,
    output logic             acc_valid,
    input  logic             acc_ready,
    output logic             busy,
    output logic             overflow,
    output logic             overrun
);
    typedef enum logic {IDLE, ACCUM} state_t;
    state_t state, state_nx;
    logic [LATENCY-1:0] vld_q, lst_q;
    logic [ACC_W-1:0] acc, acc_nx;
    logic [7:0] cnt, cnt_nx;
    logic [ACC_W:0] sum;
    logic tap_v, tap_l, hold;
    assign tap_v = vld_q[LATENCY-1];
    assign tap_l = lst_q[LATENCY-1];
    assign hold = acc_valid && !acc_ready;
    // bit ACC_W of sum is the carry out of the accumulator
    assign sum = {1'b0, (state == ACCUM) ? acc : {ACC_W{1'b0}}} + {{(ACC_W-15){1'b0}}, prod};
`ifdef MUL_ACCUMULATOR_SATURATE_EN
    assign acc_nx = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
    assign acc_nx = sum[ACC_W-1:0];
`endif
    assign cnt_nx = (state == IDLE) ? 8'd1 : (cnt == 8'hFF) ? cnt : cnt + 8'd1;
    always_ff @(posedge clk or negedge rstn)
        if (!rstn)
            state <= IDLE;
        else
            state <= clr ? IDLE : state_nx;
    always_comb state_nx = tap_v ? (tap_l ? IDLE : ACCUM) : state;
    always_comb busy = (state == ACCUM);
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_q     <= '0;
            lst_q     <= '0;
            acc       <= '0;
            cnt       <= '0;
            acc_out   <= '0;
            n_terms   <= '0;
            acc_valid <= 1'b0;
            overflow  <= 1'b0;
            overrun   <= 1'b0;
        end else if (clr) begin
            vld_q     <= '0;
            lst_q     <= '0;
            acc       <= '0;
            cnt       <= '0;
            acc_out   <= '0;
            n_terms   <= '0;
            acc_valid <= 1'b0;
            overflow  <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            vld_q[0] <= op_valid;
            lst_q[0] <= op_valid && op_last;
            for (int i = 1; i < LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                lst_q[i] <= lst_q[i-1];
            end
            if (tap_v) begin
                acc <= acc_nx;
                cnt <= cnt_nx;
            end
            if (tap_v && sum[ACC_W])
                overflow <= 1'b1;
            // a completion against an untaken result is dropped
            if (tap_v && tap_l && hold)
                overrun <= 1'b1;
            if (tap_v && tap_l && !hold) begin
                acc_out   <= acc_nx;
                n_terms   <= cnt_nx;
                acc_valid <= 1'b1;
            end else if (acc_valid && acc_ready)
                acc_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mul_accumulator.sv
// tb_mul_accumulator: vector table, corner sequences and random frames against a frame-level model.
module tb_mul_accumulator;
    localparam int LAT = 3;
    localparam int ACC_W = 24;
    localparam longint MAXV = (64'd1 << ACC_W) - 1;
    logic clk = 0, rstn = 0, op_valid = 0, op_last = 0, clr = 0, acc_ready = 0;
    logic [7:0] a = 0, b = 0;
    logic [15:0] prod;
    logic [ACC_W-1:0] acc_out;
    logic [7:0] n_terms;
    logic acc_valid, busy, overflow, overrun;
    logic [15:0] pp [LAT];
    int errors = 0, checks = 0, edge_n = 0, busy_cnt = 0, lat = 0, nt = 0;
    typedef struct {int e; bit last; longint psum; int n;} ev_t;
    ev_t evq[$];
    longint f_sum = 0, m_out = 0;
    int f_n = 0, m_n = 0;
    bit m_valid = 0, m_busy = 0, m_ovf = 0, m_ovr = 0;
    typedef struct {int n; logic [3:0][7:0] a; logic [3:0][7:0] b; longint out;} vec_t;
    vec_t vt[6];

    mul_accumulator #(.LATENCY(LAT), .ACC_W(ACC_W)) dut (
        .clk(clk), .rstn(rstn), .op_valid(op_valid), .op_last(op_last), .clr(clr),
        .prod(prod), .acc_out(acc_out), .n_terms(n_terms), .acc_valid(acc_valid),
        .acc_ready(acc_ready), .busy(busy), .overflow(overflow), .overrun(overrun)
    );

    always #5 clk = ~clk;
    // upstream multiplier: product of operands sampled at edge k is visible after edge k+LAT-1
    always @(posedge clk) begin
        pp[0] <= a * b;
        for (int i = 1; i < LAT; i++) pp[i] <= pp[i-1];
    end
    assign prod = pp[LAT-1];

    function automatic vec_t mk(int n, int a0, int b0, int a1, int b1, int a2, int b2,
                                int a3, int b3, longint out);
        vec_t v;
        v.n = n;
        v.a = {8'(a3), 8'(a2), 8'(a1), 8'(a0)};
        v.b = {8'(b3), 8'(b2), 8'(b1), 8'(b0)};
        v.out = out;
        return v;
    endfunction

    function automatic void m_reset();
        evq.delete();
        f_sum = 0; f_n = 0; m_out = 0; m_n = 0;
        m_valid = 0; m_busy = 0; m_ovf = 0; m_ovr = 0;
    endfunction

    // term issued at edge e is consumed at edge e+LAT; frame totals kept as exact integers
    function automatic void model_edge();
        ev_t ev;
        bit cmp = 0;
        longint res = 0;
        if (!rstn || clr) begin
            m_reset();
            return;
        end
        if (evq.size() > 0 && evq[0].e == edge_n) begin
            ev = evq.pop_front();
            m_busy = !ev.last;
            if (ev.psum > MAXV) m_ovf = 1;
            cmp = ev.last;
`ifdef MUL_ACCUMULATOR_SATURATE_EN
            res = (ev.psum > MAXV) ? MAXV : ev.psum;
`else
            res = ev.psum & MAXV;
`endif
        end
        if (cmp) begin
            if (m_valid && !acc_ready) m_ovr = 1;
            else begin
                m_valid = 1;
                m_out = res;
                m_n = (ev.n > 255) ? 255 : ev.n;
            end
        end else if (m_valid && acc_ready) m_valid = 0;
        if (op_valid) begin
            f_sum += longint'(a) * longint'(b);
            f_n++;
            evq.push_back('{edge_n + LAT, op_last, f_sum, f_n});
            if (op_last) begin
                f_sum = 0;
                f_n = 0;
            end
        end
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("acc_valid", acc_valid, m_valid);
        chk("busy", busy, m_busy);
        chk("overflow", overflow, m_ovf);
        chk("overrun", overrun, m_ovr);
        if (m_valid) begin
            chk("acc_out", acc_out, m_out);
            chk("n_terms", n_terms, m_n);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        edge_n++;
        model_edge();
        #1;
        if (busy) busy_cnt++;
        check_all();
    endtask

    task automatic frame1(input int x, input int y);
        op_valid = 1; op_last = 1; a = 8'(x); b = 8'(y);
        tick();
        op_valid = 0; op_last = 0;
    endtask

    task automatic wait_valid();
        lat = 0;
        while (!acc_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("valid_seen", acc_valid, 1);
    endtask

    initial begin
        vt[0] = mk(1, 3, 5, 0, 0, 0, 0, 0, 0, 15);
        vt[1] = mk(3, 1, 2, 3, 4, 5, 6, 0, 0, 44);
        vt[2] = mk(2, 255, 255, 255, 255, 0, 0, 0, 0, 130050);
        vt[3] = mk(4, 0, 7, 1, 1, 2, 3, 10, 10, 107);
        vt[4] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vt[5] = mk(2, 16, 16, 100, 200, 0, 0, 0, 0, 20256);
        tick();
        tick();
        chk("rst_acc_out", acc_out, 0);
        chk("rst_n_terms", n_terms, 0);
        rstn = 1;
        acc_ready = 1;
        foreach (vt[i]) begin
            busy_cnt = 0;
            for (int t = 0; t < vt[i].n; t++) begin
                op_valid = 1; op_last = (t == vt[i].n - 1); a = vt[i].a[t]; b = vt[i].b[t];
                tick();
            end
            op_valid = 0; op_last = 0;
            wait_valid();
            chk("vec_latency", lat, LAT);
            chk("vec_out", acc_out, vt[i].out);
            chk("vec_n", n_terms, vt[i].n);
            chk("vec_busy_cycles", busy_cnt, vt[i].n - 1);
            tick();
            chk("vec_valid_clear", acc_valid, 0);
        end
        for (int t = 0; t < 300; t++) begin
            op_valid = 1; op_last = (t == 299); a = 255; b = 255;
            tick();
        end
        op_valid = 0; op_last = 0;
        wait_valid();
        chk("ovf_n", n_terms, 255);
        chk("ovf_flag", overflow, 1);
`ifdef MUL_ACCUMULATOR_SATURATE_EN
        chk("ovf_out", acc_out, 24'hFFFFFF);
`else
        chk("ovf_out", acc_out, 2730284);
`endif
        clr = 1; tick(); clr = 0;
        chk("clr_ovf", overflow, 0);
        acc_ready = 0;
        frame1(2, 2);
        repeat (LAT + 1) tick();
        frame1(3, 3);
        repeat (LAT + 1) tick();
        chk("bp_out", acc_out, 4);
        chk("bp_overrun", overrun, 1);
        chk("bp_valid", acc_valid, 1);
        acc_ready = 1; tick();
        chk("bp_drain", acc_valid, 0);
        clr = 1; tick(); clr = 0;
        chk("clr_overrun", overrun, 0);
        acc_ready = 0;
        frame1(2, 2);
        wait_valid();
        frame1(3, 3);
        tick(); tick();
        acc_ready = 1; tick();
        chk("bp2_out", acc_out, 9);
        chk("bp2_overrun", overrun, 0);
        chk("bp2_valid", acc_valid, 1);
        tick();
        chk("bp2_clear", acc_valid, 0);
        op_valid = 1; op_last = 0; a = 7; b = 7; tick();
        a = 8; b = 8; tick();
        op_valid = 0;
        clr = 1; tick(); clr = 0;
        frame1(2, 2);
        wait_valid();
        chk("clr_frame_out", acc_out, 4);
        chk("clr_frame_n", n_terms, 1);
        chk("clr_frame_flags", {overflow, overrun}, 0);
        tick();
        op_valid = 1; op_last = 0; a = 7; b = 7; tick();
        a = 8; b = 8; tick();
        op_valid = 0;
        tick(); tick();
        chk("pre_rst_busy", busy, 1);
        #2 rstn = 0;
        m_reset();
        #1;
        check_all();
        chk("async_acc_out", acc_out, 0);
        chk("async_n_terms", n_terms, 0);
        tick();
        rstn = 1;
        frame1(2, 2);
        wait_valid();
        chk("rst_frame_out", acc_out, 4);
        chk("rst_frame_n", n_terms, 1);
        chk("rst_frame_flags", {overflow, overrun}, 0);
        for (int f = 0; f < 40; f++) begin
            nt = $urandom_range(1, 8);
            for (int t = 0; t < nt; t++) begin
                while ($urandom_range(0, 3) == 0) begin
                    op_valid = 0; op_last = 1'($urandom_range(0, 1));
                    acc_ready = ($urandom_range(0, 3) != 0);
                    tick();
                end
                op_valid = 1; op_last = (t == nt - 1); a = 8'($urandom); b = 8'($urandom);
                acc_ready = ($urandom_range(0, 3) != 0);
                tick();
            end
        end
        op_valid = 0; op_last = 0; acc_ready = 1;
        repeat (LAT + 2) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mul_accumulator.md
MUL_ACCUMULATOR -- requirements
Module: mul_accumulator

Interface
REQ-001 The block SHALL have parameter LATENCY, default 3, giving the number of clock edges from operand sampling by the upstream 8-bit pipelined multiplier to the edge at which its product is consumed here.
REQ-002 The block SHALL have parameter ACC_W, default 24, giving the accumulator and result width in bits.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rstn, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port op_valid, input, 1 bit: high in the cycle operands a,b are presented to the multiplier.
REQ-006 The block SHALL have port op_last, input, 1 bit: qualified by op_valid; marks the final term of a dot product.
REQ-007 The block SHALL have port clr, input, 1 bit: synchronous flush.
REQ-008 The block SHALL have port prod, input, 16 bits: the multiplier's unsigned product output.
REQ-009 The block SHALL have port acc_out, output, ACC_W bits: the completed dot-product result.
REQ-010 The block SHALL have port n_terms, output, 8 bits: the term count of the result in acc_out.
REQ-011 The block SHALL have port acc_valid, output, 1 bit: acc_out and n_terms hold a result.
REQ-012 The block SHALL have port acc_ready, input, 1 bit: the consumer accepts the result.
REQ-013 The block SHALL have port busy, output, 1 bit: a partial sum is in progress.
REQ-014 The block SHALL have port overflow, output, 1 bit: sticky flag; set on accumulator carry-out.
REQ-015 The block SHALL have port overrun, output, 1 bit: sticky flag; set when a result is dropped.

Function
REQ-016 The block SHALL carry op_valid/op_last through a LATENCY-deep register delay line; the tap is the last stage.
REQ-017 Operands sampled at edge k SHALL reach the tap after edge k+LATENCY-1, and prod SHALL be accumulated at edge k+LATENCY.
REQ-018 The FSM SHALL have states IDLE (no partial sum) and ACCUM (partial sum held); busy SHALL be high exactly in ACCUM.
REQ-019 A tap-valid in IDLE SHALL load acc=prod and cnt=1; a tap-valid in ACCUM SHALL load acc=acc+prod and cnt=cnt+1, with cnt saturating at 255.
REQ-020 A tap-valid without last SHALL go to or stay in ACCUM; a tap-valid with last SHALL load the final sum/count into the output register, set acc_valid and go to IDLE.
REQ-021 Arithmetic SHALL be unsigned: prod zero-extended to ACC_W+1 bits, with bit ACC_W as the carry; carry=1 SHALL set overflow.
REQ-022 acc_valid SHALL clear on an edge with acc_valid&&acc_ready; acc_out/n_terms SHALL be stable while acc_valid&&!acc_ready.
REQ-023 A completion while acc_valid&&!acc_ready SHALL discard the new result, keep the held one and set overrun.
REQ-024 A completion coinciding with acc_valid&&acc_ready SHALL load the new result, keep acc_valid=1 and SHALL NOT set overrun.
REQ-025 The block SHALL apply no backpressure upstream; the multiplier never stalls.
REQ-026 clr SHALL clear the delay line, acc, cnt, acc_out, n_terms, acc_valid, overflow and overrun, force IDLE, and take priority over every other event in that cycle.

Reset
REQ-027 When rstn=0, asynchronously: all outputs SHALL be 0, the delay line, acc and cnt SHALL be 0, and the FSM SHALL be IDLE.
REQ-028 A reset mid-frame SHALL discard the partial sum, and in-flight operands SHALL never produce a result.
REQ-029 After rstn deasserts, the first op_valid SHALL start a new frame.

Configuration
REQ-030 With macro MUL_ACCUMULATOR_SATURATE_EN defined, a carry SHALL clamp acc to 2^ACC_W-1, and the frame SHALL continue clamped.
REQ-031 Without MUL_ACCUMULATOR_SATURATE_EN, acc SHALL wrap modulo 2^ACC_W; overflow SHALL be set on carry in both builds.

Verification
REQ-032 Single term: a=3, b=5, op_valid=op_last=1 sampled at edge k, acc_ready=1 -> acc_valid=1 after edge k+3, acc_out=15, n_terms=1, and acc_valid=0 after edge k+4.
REQ-033 Back-to-back dot product: (1*2, 3*4, 5*6) on consecutive cycles, last on the third -> acc_out=44, n_terms=3, busy high for 2 cycles.
REQ-034 Overflow: 300 terms of 255*255 -> n_terms=255, overflow=1; acc_out=0xFFFFFF with SATURATE_EN, 2730284 without.
REQ-035 Backpressure: acc_ready=0, two single-term frames 4 and 9 -> acc_out stays 4, overrun=1; same with acc_ready=1 in the second completion cycle -> acc_out=9, overrun=0.
REQ-036 Interrupted frame: clr, or rstn=0, asserted after 2 terms of a 3-term frame, then a new frame 2*2 with last -> acc_out=4, n_terms=1, flags 0.
